seven_segment_mux_driver: RTL and testbench

//   Parametrised time-multiplexed hex driver for common-anode 7-segment banks.

---
 rtl/seven_segment_mux_driver.sv | 136 +++++++++++++
 tb/tb_seven_segment_mux_driver.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux_driver.sv
// Time-multiplexed hex driver for a bank of 7-segment digits with frame-synchronous
// updates, leading-zero blanking, decimal points, PWM brightness and an anti-ghost gap.
module seven_segment_mux_driver #(
    parameter int NUM_DIGITS = 8,
    parameter int DIV_WIDTH  = 10,
    parameter int BRIGHT_W   = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      blank_lz,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [6:0]                segment_cathode,
    output logic [NUM_DIGITS-1:0]     segment_anode,
    output logic                      segment_dp,
    output logic                      frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_WIDTH-1:0]  PRESC_MAX = '1;
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            SEG_OFF   = {7{ACTIVE_LOW}};

    logic [DIV_WIDTH-1:0]  presc;
    logic [IDX_W-1:0]      idx;
    logic [4*NUM_DIGITS-1:0] disp_word;
    logic [4*NUM_DIGITS-1:0] pend_word;
    logic [NUM_DIGITS-1:0] disp_dp;
    logic [NUM_DIGITS-1:0] pend_dp;
    logic                  pend_full;

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] lz_mask;
    logic [BRIGHT_W-1:0]   phase;
    logic [NUM_DIGITS-1:0] anode_sel;
    logic                  slot_end;
    logic                  frame_end;
    logic                  accept;
    logic                  commit;
    logic                  digit_on;

    // Glyph table in active-low form (0 = segment lit), bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0:    hex_glyph = 7'b0000001;
            4'h1:    hex_glyph = 7'b1001111;
            4'h2:    hex_glyph = 7'b0010010;
            4'h3:    hex_glyph = 7'b0000110;
            4'h4:    hex_glyph = 7'b1001100;
            4'h5:    hex_glyph = 7'b0100100;
            4'h6:    hex_glyph = 7'b0100000;
            4'h7:    hex_glyph = 7'b0001111;
            4'h8:    hex_glyph = 7'b0000000;
            4'h9:    hex_glyph = 7'b0000100;
            4'hA:    hex_glyph = 7'b0001000;
            4'hB:    hex_glyph = 7'b1100000;
            4'hC:    hex_glyph = 7'b0110001;
            4'hD:    hex_glyph = 7'b1000010;
            4'hE:    hex_glyph = 7'b0110000;
            default: hex_glyph = 7'b0111000;
        endcase
    endfunction

    // lz_mask[i] is set when nibbles i..top are all zero; digit 0 is never blanked.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign nib[g] = disp_word[4*g +: 4];
        if (g == 0) begin : g_first
            assign lz_mask[g] = 1'b0;
        end else begin : g_rest
            assign lz_mask[g] = (disp_word[4*NUM_DIGITS-1:4*g] == '0);
        end
    end

    assign phase      = presc[DIV_WIDTH-1 -: BRIGHT_W];
    assign slot_end   = (presc == PRESC_MAX);
    assign frame_end  = slot_end && (idx == LAST_IDX);
    assign accept     = data_valid && !pend_full;
    assign commit     = frame_end && pend_full;
    assign data_ready = !pend_full;
    assign anode_sel  = ONE_HOT0 << idx;
    assign digit_on   = digit_en[idx] && (presc != '0) && (phase <= brightness)
                        && !(blank_lz && lz_mask[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc           <= '0;
            idx             <= '0;
            disp_word       <= '0;
            disp_dp         <= '0;
            pend_word       <= '0;
            pend_dp         <= '0;
            pend_full       <= 1'b0;
            frame_tick      <= 1'b0;
            segment_anode   <= ANODE_OFF;
            segment_cathode <= SEG_OFF;
            segment_dp      <= ACTIVE_LOW;
        end else begin
            presc <= presc + 1'b1;
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end

            // Accept needs an empty buffer and commit a full one, so they never collide.
            if (accept) begin
                pend_word <= data_in;
                pend_dp   <= dp_in;
                pend_full <= 1'b1;
            end else if (commit) begin
                disp_word <= pend_word;
                disp_dp   <= pend_dp;
                pend_full <= 1'b0;
            end

            frame_tick <= frame_end;

            // Output stage: everything below lags prescaler/index by one clock.
            if (digit_on) begin
                segment_anode   <= anode_sel ^ ANODE_OFF;
                segment_cathode <= hex_glyph(nib[idx]) ^ {7{~ACTIVE_LOW}};
                segment_dp      <= disp_dp[idx] ? ~ACTIVE_LOW : ACTIVE_LOW;
            end else begin
                segment_anode   <= ANODE_OFF;
                segment_cathode <= SEG_OFF;
                segment_dp      <= ACTIVE_LOW;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Directed and randomized bench for seven_segment_mux_driver (8 digits, 16-clock slots,
// 4 brightness phases, active-low), compared cycle by cycle against a time-based model.
module tb_seven_segment_mux_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        data_valid;
    logic        data_ready;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic [1:0]  brightness;
    logic [6:0]  segment_cathode;
    logic [7:0]  segment_anode;
    logic        segment_dp;
    logic        frame_tick;

    seven_segment_mux_driver #(
        .NUM_DIGITS (8),
        .DIV_WIDTH  (4),
        .BRIGHT_W   (2),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_in         (data_in),
        .dp_in           (dp_in),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .digit_en        (digit_en),
        .blank_lz        (blank_lz),
        .brightness      (brightness),
        .segment_cathode (segment_cathode),
        .segment_anode   (segment_anode),
        .segment_dp      (segment_dp),
        .frame_tick      (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: time since reset release plus pending/display words.
    int          k;
    logic [31:0] m_disp, m_pend;
    logic [7:0]  m_disp_dp, m_pend_dp;
    bit          m_full;
    bit          accepted;
    bit          prev_tick;

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic [7:0] seen_on;
    int         on_cnt0;
    int         dp_low_cnt;
    int         dp_bad;
    int         bad_zero;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        seen_on    = 8'h00;
        on_cnt0    = 0;
        dp_low_cnt = 0;
        dp_bad     = 0;
        bad_zero   = 0;
    endtask

    task automatic step();
        int         p;
        int         d;
        logic [2:0] di;
        logic [3:0] nibv;
        bit         on;
        bit         bnd;
        logic [7:0] ea;
        logic [6:0] ec;
        logic       edp;
        prev_tick = frame_tick;
        @(posedge clk);
        p    = k % 16;
        d    = (k / 16) % 8;
        di   = 3'(d);
        nibv = 4'(m_disp >> (4 * d));
        on   = digit_en[di] && (p != 0) && ((p / 4) <= int'(brightness))
               && !(blank_lz && (d > 0) && ((m_disp >> (4 * d)) == 32'd0));
        ea   = on ? ~(8'd1 << di) : 8'hFF;
        ec   = on ? glyph[nibv] : 7'h7F;
        edp  = on ? ~m_disp_dp[di] : 1'b1;
        bnd  = (k % 128) == 127;
        accepted = 1'b0;
        if (bnd && m_full) begin
            m_disp    = m_pend;
            m_disp_dp = m_pend_dp;
            m_full    = 1'b0;
        end else if (data_valid && !m_full) begin
            m_pend    = data_in;
            m_pend_dp = dp_in;
            m_full    = 1'b1;
            accepted  = 1'b1;
        end
        k++;
        #1;
        check("cycle", 64'({segment_anode, segment_cathode, segment_dp, data_ready, frame_tick}),
              64'({ea, ec, edp, !m_full, bnd}));
        if (segment_anode != 8'hFF) begin
            seen_on = seen_on | ~segment_anode;
            if (segment_cathode != 7'b0000001) bad_zero++;
        end
        if (!segment_anode[0]) on_cnt0++;
        if (!segment_dp) begin
            dp_low_cnt++;
            if (segment_anode != 8'hFE) dp_bad++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_tick();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = frame_tick;
        end
        if (!got) check("tick_timeout", 64'(0), 64'(1));
    endtask

    task automatic send(input logic [31:0] w, input logic [7:0] dp);
        bit got;
        data_in    = w;
        dp_in      = dp;
        data_valid = 1'b1;
        got        = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            got = accepted;
        end
        data_valid = 1'b0;
        if (!got) check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        check("reset_async", 64'({segment_anode, segment_cathode, segment_dp, data_ready, frame_tick}),
              64'({8'hFF, 7'h7F, 1'b1, 1'b1, 1'b0}));
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 64'({segment_anode, segment_cathode, segment_dp, data_ready, frame_tick}),
              64'({8'hFF, 7'h7F, 1'b1, 1'b1, 1'b0}));
        rst_n     = 1'b1;
        k         = 0;
        m_disp    = '0;
        m_pend    = '0;
        m_disp_dp = '0;
        m_pend_dp = '0;
        m_full    = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        data_in    = '0;
        dp_in      = '0;
        data_valid = 1'b0;
        digit_en   = 8'hFF;
        blank_lz   = 1'b0;
        brightness = 2'd3;
        clear_obs();
        #2;
        reset_dut();
        run(40);

        // Load a word: ready stays low until the frame boundary, then digit 0 shows 'd'.
        send(32'h1234ABCD, 8'h00);
        wait_tick();
        step();
        step();
        check("digit0_first", 64'({segment_anode, segment_cathode}), 64'({8'hFE, 7'b1000010}));

        // Leading-zero blanking.
        blank_lz = 1'b1;
        send(32'h00000050, 8'h00);
        wait_tick();
        clear_obs();
        run(128);
        check("blank_50_seen", 64'(seen_on), 64'(8'h03));
        send(32'h00000000, 8'h00);
        wait_tick();
        clear_obs();
        run(128);
        check("blank_0_seen", 64'(seen_on), 64'(8'h01));

        // PWM brightness extremes.
        blank_lz   = 1'b0;
        brightness = 2'd0;
        wait_tick();
        clear_obs();
        run(128);
        check("bright0_on", 64'(on_cnt0), 64'(3));
        brightness = 2'd3;
        wait_tick();
        clear_obs();
        run(128);
        check("bright3_on", 64'(on_cnt0), 64'(15));
        check("bright3_seen", 64'(seen_on), 64'(8'hFF));

        // Per-digit enable and decimal point.
        digit_en = 8'h0F;
        send(32'h12345678, 8'h01);
        wait_tick();
        clear_obs();
        run(128);
        check("en_seen", 64'(seen_on), 64'(8'h0F));
        check("dp_other_digit", 64'(dp_bad), 64'(0));
        check("dp_low_count", 64'(dp_low_cnt), 64'(15));

        // Valid held while pending is full: second word waits for the commit.
        digit_en = 8'hFF;
        send(32'hA5A5A5A5, 8'hF0);
        data_in    = 32'h9876FEDC;
        dp_in      = 8'h0F;
        data_valid = 1'b1;
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 300 && !got; i++) begin
                step();
                got = accepted;
            end
            data_valid = 1'b0;
            check("second_accepted", 64'(got), 64'(1));
            check("second_after_commit", 64'(prev_tick), 64'(1));
        end

        // Reset with the second word pending: it must never reach the display.
        run(5);
        reset_dut();
        clear_obs();
        run(300);
        check("no_commit_after_reset", 64'(bad_zero), 64'(0));

        // Randomized traffic and control changes.
        for (int n = 0; n < 16; n++) begin
            logic [31:0] w;
            w          = $urandom >> (4 * $urandom_range(0, 7));
            brightness = 2'($urandom_range(0, 3));
            digit_en   = 8'($urandom);
            blank_lz   = 1'($urandom_range(0, 1));
            send(w, 8'($urandom));
            run($urandom_range(20, 250));
            if ($urandom_range(0, 3) == 0) begin
                data_in    = $urandom;
                dp_in      = 8'($urandom);
                data_valid = 1'b1;
                run($urandom_range(1, 200));
                data_valid = 1'b0;
            end
        end
        run(150);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
